// File: rtl/ram8.sv
// 8-word register-file RAM: combinational read, synchronous single-port write,
// synchronous active-low clear. Base bank for the larger RAM hierarchy.
module ram8 #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DEPTH-1:0] load_sel;
  logic [WIDTH-1:0] word_d [DEPTH];
  logic [WIDTH-1:0] word_q [DEPTH];

  // Load demux: only the addressed register sees the write enable.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_sel          = '0;
    load_sel[address] = load;
  end

  // Clear wins over a write on the same edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      word_d[i] = word_q[i];
      if (!rst_n) begin
        word_d[i] = '0;
      end else if (load_sel[i]) begin
        word_d[i] = in;
      end
    end
  end

  // NOTE: these words are discrete registers with a functional clear, so resetting
  // the whole array is intended behaviour rather than a cost imposed on a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: non-blocking assignment keeps every register updating on the same edge.
      word_q[i] <= word_d[i];
    end
  end

  // Read mux: zero-latency view of the addressed word, no write bypass.
  always_comb begin
    out = word_q[address];
  end

endmodule

// File: tb/tb_ram8.sv
// Directed self-checking bench for ram8: a reference memory feeds a scoreboard
// queue that each combinational read is compared against.
module tb_ram8;

  localparam int WIDTH     = 16;
  localparam int ADDR_BITS = 3;
  localparam int DEPTH     = 2 ** ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 load;
  logic [ADDR_BITS-1:0] address;
  logic [WIDTH-1:0]     in;
  logic [WIDTH-1:0]     out;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int compared   = 0;
  int mismatched = 0;

  ram8 #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .address (address),
    .in      (in),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                       input logic [WIDTH-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive the address, queue the model's value, then compare once the read settles.
  task automatic expect_read(input int a, input string tag);
    logic [WIDTH-1:0] exp;
    exp_q.push_back(mem[a]);
    address = ADDR_BITS'(a);
    #1;
    exp = exp_q.pop_front();
    check($sformatf("%s[a%0d]", tag, a), out, exp);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) expect_read(a, tag);
  endtask

  task automatic write_word(input int a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    address = ADDR_BITS'(a);
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load   = 1'b0;
    mem[a] = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    address = '0;
    in      = '0;

    // Initial reset
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    sweep("por_clear");

    // Reset clear with a competing write
    for (int a = 0; a < DEPTH; a++) write_word(a, 16'hFFFF);
    expect_read(0, "fill_ffff");
    expect_read(7, "fill_ffff");
    @(negedge clk);
    rst_n   = 1'b0;
    load    = 1'b1;
    in      = 16'h1234;
    address = 3'd3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    sweep("rst_clear");

    // Sequential fill and readback
    for (int a = 0; a < DEPTH; a++) write_word(a, WIDTH'(a + 1));
    sweep("seq_fill");

    // Write isolation
    write_word(5, 16'hBEEF);
    sweep("isolate");

    // Load low ignored
    @(negedge clk);
    address = 3'd3;
    in      = 16'hAAAA;
    load    = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      expect_read(3, $sformatf("load_low_e%0d", e));
    end

    // Read timing: old value until the edge, new value after it
    @(negedge clk);
    expect_read(2, "pre_write");
    #2;
    in   = 16'h00FF;
    load = 1'b1;
    #1;
    check("mid_cycle_no_bypass", out, 16'h0003);
    @(posedge clk);
    #1;
    load   = 1'b0;
    mem[2] = 16'h00FF;
    expect_read(2, "post_write");
    expect_read(6, "addr_change");

    // Overwrite on consecutive edges
    @(negedge clk);
    address = 3'd7;
    in      = 16'h1111;
    load    = 1'b1;
    @(posedge clk);
    #1;
    in = 16'h2222;
    @(posedge clk);
    #1;
    load   = 1'b0;
    mem[7] = 16'h2222;
    expect_read(7, "overwrite");

    // Held load with changing data at one address
    @(negedge clk);
    address = 3'd0;
    in      = 16'h0001;
    load    = 1'b1;
    @(posedge clk);
    #1;
    in = 16'h0002;
    @(posedge clk);
    #1;
    load   = 1'b0;
    mem[0] = 16'h0002;
    sweep("held_load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram8.md
Name: ram8

Overview:
- 8-word × 16-bit random-access memory built from registers, in the Hack-style memory hierarchy.
- Serves as the base bank that larger RAM blocks (RAM64 and up) compose from.
- Combinational read port and synchronous single-port write on the rising clock edge.
- Synchronous active-low clear of all words.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 3, address width; depth = 2**ADDR_BITS = 8 words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset; clears every word.
- load  input  1  write enable; sampled on the rising edge of clk.
- address  input  ADDR_BITS  selects the word for both read and write.
- in  input  WIDTH  write data.
- out  output  WIDTH  read data = contents of word[address].

Behaviour:
- Storage: 8 independent WIDTH-bit registers, word[0..7].
- Reset: already decided — one clock, clk; reset rst_n is synchronous and active-low.
  - At a rising edge with rst_n=0, every word becomes 0.
  - load, address and in are ignored on that edge, so reset has priority over a write.
  - Asserting reset mid-write sequence discards that edge's write.
  - After reset, out = 0 for every address.
- Power-up contents before the first reset are undefined. The bench must reset first.
- Write: at a rising edge with rst_n=1 and load=1, word[address] <= in.
  - All other words hold.
  - Exactly one word is written per edge.
- Hold: at a rising edge with rst_n=1 and load=0, all words hold.
- Read is combinational, with zero-cycle latency from address:
  - out = word[address] at all times.
  - A change of address alone updates out immediately, with no clock needed.
- Write visibility:
  - Before the writing edge, out shows the old contents.
  - Immediately after the edge, out shows the new value, because the addressed word changed.
  - No read-during-write bypass from in to out is provided before the edge.
- in and load changes between edges have no effect on stored data.
- Address wrap: address is exactly ADDR_BITS wide. Every value 0..7 is valid; there is no out-of-range case.
- Width rules:
  - in is stored unmodified; there is no sign extension or truncation.
  - out is driven from a single selected word through an 8:1 WIDTH-bit mux.
- Implementation structure:
  - One 3-to-8 load demux (DMux8Way-style) gating load to the selected register.
  - Eight WIDTH-bit registers, each with load and synchronous clear.
  - One 8:1 output mux (Mux8Way16-style).
- No X propagation requirements beyond standard simulation semantics.

Test Plan:
- Reset clear:
  - Write 0xFFFF to all 8 words.
  - Hold rst_n=0 for one edge with load=1, in=0x1234.
  - Required: out=0x0000 for address 0..7; 0x1234 is not written.
- Sequential fill and readback:
  - With load=1, write in=address+1 to addresses 0..7, one per edge.
  - Then set load=0 and sweep address 0..7.
  - Required: out = 0x0001..0x0008 respectively.
- Write isolation:
  - Write 0xBEEF to address 5 only.
  - Required: address 5 reads 0xBEEF; every other address keeps its previous value.
- Load low ignored:
  - With load=0, drive in=0xAAAA across several edges at address 3 (previous value 0x0004).
  - Required: out stays 0x0004.
- Read timing:
  - Address 2 holds 0x0003.
  - Set in=0x00FF and load=1 mid-cycle.
  - Required: out stays 0x0003 until the rising edge, then reads 0x00FF.
  - Changing address to 6 without a clock edge immediately shows word[6].
- Overwrite with hold:
  - Write address 7 twice, first 0x1111 then 0x2222, on consecutive edges.
  - Required: reads 0x2222 thereafter.
  - Hold load=1 at the same address across two edges with in changing 0x0001→0x0002. Required: final value 0x0002.
